mem_arbiter: RTL and testbench

- Shares one single-port word memory (combinational read, write on posedge clk, word-aligned) between the instruction-fetch requester and the MEM-stage data requester of the pipelined MIPS core.
- At most one access per cycle.
- Data has fixed priority, with a starvation guard for instruction fetch.
- Read data is registered and returned one cycle after grant; the pipeline stalls on ~gnt.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/arb_starve_ctr.sv | 35 +++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int WORD_OFS = 2;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_I,
        GNT_D
    } grant_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive denied instruction-request cycles.
// Raises force_o once the count reaches STARVE_MAX while i_req_i is held.
module arb_starve_ctr #(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_req_i,
    input  logic i_gnt_i,
    output logic force_o
);
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (i_req_i && !i_gnt_i) begin
            cnt_d = (cnt_q == MAX_C) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_o = (cnt_q == MAX_C) && i_req_i;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data has fixed priority, instruction fetch is
// force-granted after STARVE_MAX denied cycles. Optional counters: MEM_ARB_PERF_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 6,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_a,
    output logic [31:0]       m_wd,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]       perf_i_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_conflicts,
`endif
    input  logic [31:0]       m_rd
);
    mem_req_t i_bus;
    mem_req_t d_bus;
    grant_e   grant;
    logic     force_i;

    logic        i_rvalid_q, i_rvalid_d;
    logic [31:0] i_rdata_q,  i_rdata_d;
    logic        d_rvalid_q, d_rvalid_d;
    logic [31:0] d_rdata_q,  d_rdata_d;

    always_comb begin
        i_bus       = '0;
        i_bus.req   = i_req;
        i_bus.addr  = i_addr;
        d_bus.req   = d_req;
        d_bus.we    = d_we;
        d_bus.addr  = d_addr;
        d_bus.wdata = d_wdata;
    end

    arb_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk     (clk),
        .reset_n (reset_n),
        .i_req_i (i_bus.req),
        .i_gnt_i (i_gnt),
        .force_o (force_i)
    );

    // Grants are suppressed while reset is asserted so nothing reaches memory.
    always_comb begin
        grant = GNT_NONE;
        if (!reset_n) begin
            grant = GNT_NONE;
        end else if (force_i) begin
            grant = GNT_I;
        end else if (d_bus.req) begin
            grant = GNT_D;
        end else if (i_bus.req) begin
            grant = GNT_I;
        end
    end

    assign i_gnt = (grant == GNT_I);
    assign d_gnt = (grant == GNT_D);

    // Address bits above the memory depth wrap; byte offset is dropped.
    always_comb begin
        m_a  = '0;
        m_we = 1'b0;
        m_wd = d_bus.wdata;
        case (grant)
            GNT_I:   m_a = i_bus.addr[ADDR_W+WORD_OFS-1:WORD_OFS];
            GNT_D: begin
                m_a  = d_bus.addr[ADDR_W+WORD_OFS-1:WORD_OFS];
                m_we = d_bus.we;
            end
            default: m_a = '0;
        endcase
    end

    always_comb begin
        i_rvalid_d = i_gnt;
        i_rdata_d  = i_gnt ? m_rd : i_rdata_q;
        d_rvalid_d = d_gnt && !d_bus.we;
        d_rdata_d  = (d_gnt && !d_bus.we) ? m_rd : d_rdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rvalid_q <= 1'b0;
            d_rdata_q  <= '0;
        end else begin
            i_rvalid_q <= i_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            d_rvalid_q <= d_rvalid_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign i_rvalid = i_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign d_rvalid = d_rvalid_q;
    assign d_rdata  = d_rdata_q;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_i_q, perf_d_q, perf_c_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_i_q <= '0;
            perf_d_q <= '0;
            perf_c_q <= '0;
        end else begin
            perf_i_q <= perf_i_q + {31'd0, i_gnt};
            perf_d_q <= perf_d_q + {31'd0, d_gnt};
            perf_c_q <= perf_c_q + {31'd0, (i_bus.req && d_bus.req)};
        end
    end

    assign perf_i_grants  = perf_i_q;
    assign perf_d_grants  = perf_d_q;
    assign perf_conflicts = perf_c_q;
`endif

    // Instruction side never writes; address bits outside the word index are don't-care.
    logic unused_bits;
    assign unused_bits = ^{i_bus.we, i_bus.wdata,
                           i_bus.addr[31:ADDR_W+WORD_OFS], i_bus.addr[WORD_OFS-1:0],
                           d_bus.addr[31:ADDR_W+WORD_OFS], d_bus.addr[WORD_OFS-1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural word memory.
// Build with +define+MEM_ARB_PERF_EN to also exercise the performance counters.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_we;
    logic [31:0] i_rdata, d_rdata, m_wd, m_rd;
    logic [5:0]  m_a;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_i_grants, perf_d_grants, perf_conflicts;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [64];

    always #5 clk = ~clk;

    assign m_rd = mem[m_a];
    always @(posedge clk) if (m_we) mem[m_a] <= m_wd;

    mem_arbiter #(.ADDR_W(6), .STARVE_MAX(3)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .m_we     (m_we),
        .m_a      (m_a),
        .m_wd     (m_wd),
`ifdef MEM_ARB_PERF_EN
        .perf_i_grants  (perf_i_grants),
        .perf_d_grants  (perf_d_grants),
        .perf_conflicts (perf_conflicts),
`endif
        .m_rd     (m_rd)
    );

    task automatic test_reset();
        reset_n = 1'b0;
        i_req = 1'b1; i_addr = 32'h8;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h54; d_wdata = 32'h1234_5678;
        #1;
        checks++;
        if ({i_gnt, d_gnt, m_we} !== 3'b000) begin
            failures++;
            $display("FAIL reset_grants: got i_gnt/d_gnt/m_we=%b expected 000", {i_gnt, d_gnt, m_we});
        end
        @(posedge clk); #1;
        checks++;
        if ({i_rvalid, d_rvalid, i_rdata, d_rdata} !== 66'd0) begin
            failures++;
            $display("FAIL reset_regs: got rvalid=%b%b i_rdata=%h d_rdata=%h expected all 0",
                     i_rvalid, d_rvalid, i_rdata, d_rdata);
        end
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        reset_n = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_ifetch();
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h8;
        #1;
        checks++;
        if ({i_gnt, d_gnt, m_a} !== {2'b10, 6'd2}) begin
            failures++;
            $display("FAIL ifetch_grant: got i_gnt=%b d_gnt=%b m_a=%0d expected 1 0 2", i_gnt, d_gnt, m_a);
        end
        @(posedge clk); #1;
        checks++;
        if ({i_rvalid, i_rdata} !== {1'b1, 32'h2002_0005}) begin
            failures++;
            $display("FAIL ifetch_data: got rvalid=%b rdata=%h expected 1 20020005", i_rvalid, i_rdata);
        end
        @(negedge clk);
        i_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({i_rvalid, i_rdata} !== {1'b0, 32'h2002_0005}) begin
            failures++;
            $display("FAIL ifetch_hold: got rvalid=%b rdata=%h expected 0 20020005", i_rvalid, i_rdata);
        end
        $display("txn ifetch addr=0x8 rdata=%h", i_rdata);
    endtask

    task automatic test_raw();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h54; d_wdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({d_gnt, i_gnt, m_we, m_a, m_wd} !== {3'b101, 6'd21, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL raw_write: got d_gnt=%b i_gnt=%b m_we=%b m_a=%0d m_wd=%h expected 1 0 1 21 deadbeef",
                     d_gnt, i_gnt, m_we, m_a, m_wd);
        end
        @(posedge clk); #1;
        checks++;
        if (d_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL raw_write_norvalid: got d_rvalid=%b expected 0", d_rvalid);
        end
        @(negedge clk);
        d_we = 1'b0;
        #1;
        checks++;
        if ({d_gnt, m_we} !== 2'b10) begin
            failures++;
            $display("FAIL raw_read_grant: got d_gnt=%b m_we=%b expected 1 0", d_gnt, m_we);
        end
        @(posedge clk); #1;
        checks++;
        if ({d_rvalid, d_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL raw_read_data: got rvalid=%b rdata=%h expected 1 deadbeef", d_rvalid, d_rdata);
        end
        @(negedge clk);
        d_req = 1'b0;
        $display("txn write+read addr=0x54 rdata=%h", d_rdata);
    endtask

    task automatic test_starvation();
        logic [4:0] exp_d = 5'b10111;   // bit c: data granted in cycle c
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h8;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h54;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if ({d_gnt, i_gnt} !== {exp_d[c], ~exp_d[c]}) begin
                failures++;
                $display("FAIL starve_cycle%0d: got d_gnt=%b i_gnt=%b expected %b %b",
                         c, d_gnt, i_gnt, exp_d[c], ~exp_d[c]);
            end
            @(posedge clk); #1;
            if (c == 3) begin
                checks++;
                if ({i_rvalid, i_rdata} !== {1'b1, 32'h2002_0005}) begin
                    failures++;
                    $display("FAIL starve_forced_fetch: got rvalid=%b rdata=%h expected 1 20020005",
                             i_rvalid, i_rdata);
                end
            end
            @(negedge clk);
        end
        i_req = 1'b0; d_req = 1'b0;
        $display("txn starvation sequence done");
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_d = 4'b0111;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h8;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h54;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        checks++;
        if (d_rvalid !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre: got d_rvalid=%b expected 1", d_rvalid);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({d_rvalid, i_rvalid, d_rdata, i_gnt, d_gnt} !== 36'd0) begin
            failures++;
            $display("FAIL midrst_async: got d_rvalid=%b i_rvalid=%b d_rdata=%h gnt=%b%b expected all 0",
                     d_rvalid, i_rvalid, d_rdata, i_gnt, d_gnt);
        end
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        // A cleared counter means the forced fetch lands on the fourth cycle again.
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if ({d_gnt, i_gnt} !== {exp_d[c], ~exp_d[c]}) begin
                failures++;
                $display("FAIL midrst_cnt_cycle%0d: got d_gnt=%b i_gnt=%b expected %b %b",
                         c, d_gnt, i_gnt, exp_d[c], ~exp_d[c]);
            end
            @(negedge clk);
        end
        i_req = 1'b0; d_req = 1'b0;
        $display("txn reset mid-operation done");
    endtask

    task automatic test_addr_wrap();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
        #1;
        checks++;
        if (m_a !== 6'd1) begin
            failures++;
            $display("FAIL wrap_0x104: got m_a=%0d expected 1", m_a);
        end
        @(negedge clk);
        d_addr = 32'h57;
        #1;
        checks++;
        if (m_a !== 6'd21) begin
            failures++;
            $display("FAIL wrap_0x57: got m_a=%0d expected 21", m_a);
        end
        @(posedge clk); #1;
        checks++;
        if (d_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL wrap_0x57_data: got d_rdata=%h expected deadbeef", d_rdata);
        end
        @(negedge clk);
        d_req = 1'b0; d_we = 1'b1; d_addr = 32'hFC;
        #1;
        checks++;
        if ({i_gnt, d_gnt, m_we, m_a} !== 9'd0) begin
            failures++;
            $display("FAIL idle_bus: got gnt=%b%b m_we=%b m_a=%0d expected 0 0 0 0", i_gnt, d_gnt, m_we, m_a);
        end
        d_we = 1'b0;
        $display("txn address wrap checks done");
    endtask

`ifdef MEM_ARB_PERF_EN
    task automatic test_perf();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        i_req = 1'b1; i_addr = 32'h8;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h54;
        repeat (4) @(negedge clk);
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        i_req = 1'b0;
        checks++;
        if ({perf_conflicts, perf_i_grants, perf_d_grants} !== {32'd4, 32'd3, 32'd3}) begin
            failures++;
            $display("FAIL perf_counts: got conflicts=%0d i=%0d d=%0d expected 4 3 3",
                     perf_conflicts, perf_i_grants, perf_d_grants);
        end
        $display("txn perf counters conflicts=%0d i=%0d d=%0d", perf_conflicts, perf_i_grants, perf_d_grants);
    endtask
`endif

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = 32'h0;
        mem[2] = 32'h2002_0005;
        test_reset();
        test_ifetch();
        test_raw();
        test_starvation();
        test_reset_mid();
        test_addr_wrap();
`ifdef MEM_ARB_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    always @(negedge clk) begin
        if (i_gnt && d_gnt) begin
            failures++;
            $display("FAIL both_grants: got i_gnt=1 d_gnt=1 expected at most one");
        end
    end

endmodule
